// File: rtl/mc_fetch_regs.sv
// Multicycle MIPS inter-cycle registers: PC, IR, MDR, A, B, ALUOut, plus
// PC-alignment fault capture and debug cycle/fetch counters.
module mc_fetch_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        ir_write,
  input  logic [1:0]  pc_source,
  input  logic        iord,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] alu_result,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  input  logic        fault_clr,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm16,
  output logic [31:0] mdr,
  output logic [31:0] a_reg,
  output logic [31:0] b_reg,
  output logic [31:0] alu_out,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        pc_fault,
  output logic [31:0] fault_pc,
  output logic [31:0] cycle_count,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, mdr_q, a_q, b_q, alu_out_q;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        pc_fault_q, pc_fault_d;
  logic [31:0] cycle_count_q, fetch_count_q;
  logic [31:0] npc;
  logic [31:0] jt;

  // Jump target uses the already-incremented PC and the current instruction.
  assign jt = {pc_q[31:28], ir_q[25:0], 2'b00};

  always_comb begin
    npc = alu_result;
    case (pc_source)
      2'd0: npc = alu_result;
      2'd1: npc = alu_out_q;
      2'd2: npc = jt;
      2'd3: npc = a_q;
      default: npc = alu_result;
    endcase
  end

  // A fault in the same cycle as fault_clr wins; otherwise only the first fault is kept.
  always_comb begin
    pc_d       = pc_q;
    pc_fault_d = pc_fault_q;
    fault_pc_d = fault_pc_q;
    if (fault_clr) begin
      pc_fault_d = 1'b0;
      fault_pc_d = 32'h0;
    end
    if (pc_write) begin
      pc_d = {npc[31:2], 2'b00};
      if (npc[1:0] != 2'b00) begin
        pc_fault_d = 1'b1;
        if (!pc_fault_q || fault_clr) fault_pc_d = npc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      ir_q          <= 32'h0;
      mdr_q         <= 32'h0;
      a_q           <= 32'h0;
      b_q           <= 32'h0;
      alu_out_q     <= 32'h0;
      pc_fault_q    <= 1'b0;
      fault_pc_q    <= 32'h0;
      cycle_count_q <= 32'h0;
      fetch_count_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      pc_fault_q    <= pc_fault_d;
      fault_pc_q    <= fault_pc_d;
      mdr_q         <= mem_rdata;
      a_q           <= rf_rd1;
      b_q           <= rf_rd2;
      alu_out_q     <= alu_result;
      cycle_count_q <= cycle_count_q + 32'd1;
      if (ir_write) begin
        ir_q          <= mem_rdata;
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign op          = ir_q[31:26];
  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign rd          = ir_q[15:11];
  assign shamt       = ir_q[10:6];
  assign funct       = ir_q[5:0];
  assign imm16       = ir_q[15:0];
  assign mdr         = mdr_q;
  assign a_reg       = a_q;
  assign b_reg       = b_q;
  assign alu_out     = alu_out_q;
  assign mem_addr    = iord ? alu_out_q : pc_q;
  assign mem_wdata   = b_q;
  assign pc_fault    = pc_fault_q;
  assign fault_pc    = fault_pc_q;
  assign cycle_count = cycle_count_q;
  assign fetch_count = fetch_count_q;

endmodule
